// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the multicycle MIPS control path:
//     - opcode encodings recognised by the main control FSM
//     - state encoding of the main control FSM (also exported as a debug port)
//     - ALUOp codes, which the ALU control unit also imports
//     - ALUSrcB and PCSource select codes
//   No ports; imported with "import mips_pkg::*;".
// -----------------------------------------------------------------------------
package mips_pkg;

  // Instruction opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Main control states. Codes 12..15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // ALUOp codes consumed by the ALU control stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the control unit can sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/main_control_outputs.sv
// -----------------------------------------------------------------------------
// main_control_outputs
//   Combinational Moore decode of the datapath control signals from the
//   current FSM state. The only non-Moore terms are the memory handshake
//   gates (IRWrite/PCWrite in FETCH, InstrDone in MEMWR), which follow
//   MemReady. While reset is high every write enable and the InstrDone
//   pulse are forced low so an aborted instruction leaves no trace.
// Ports
//   State      in  current FSM state
//   MemReady   in  memory finished the current access this cycle
//   reset      in  synchronous active-high reset (gates write enables)
//   PCWrite .. PCSource, InstrDone  out  datapath controls
// -----------------------------------------------------------------------------
module main_control_outputs
  import mips_pkg::*;
(
  input  state_t     State,
  input  logic       MemReady,
  input  logic       reset,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone
);

  always_comb begin
    // NOTE: every output gets a default before the case so that states which
    // do not mention a signal drive 0 rather than infer a latch.
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    InstrDone   = 1'b0;

    case (State)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        // IR and PC+4 are captured only once the fetch data is valid
        IRWrite  = MemReady;
        PCWrite  = MemReady;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        ALUSrcB = SRCB_IMM_SH2;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REGB;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        InstrDone   = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = PCSRC_JUMP;
        InstrDone = 1'b1;
      end
      default: ; // unused codes: everything stays 0
    endcase

    // Reset aborts whatever is in flight: no architectural write this cycle.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      InstrDone   = 1'b0;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm
//   Multicycle main control unit for the MIPS datapath. Sequences each
//   instruction FETCH -> DECODE -> (execute/memory/writeback) -> FETCH based
//   on the opcode, waits on MemReady in the memory states, and flags retired
//   (InstrDone) and unsupported (IllegalOp) instructions.
// Ports
//   clk        in   clock, all state changes on rising edge
//   reset      in   synchronous active-high reset, loads FETCH
//   Opcode     in   instruction [31:26] from the instruction register
//   MemReady   in   memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource   out  datapath controls
//   State      out  current state code (debug/verification)
//   InstrDone  out  pulse in the last cycle of a retired instruction
//   IllegalOp  out  pulse in DECODE for an unsupported opcode
// -----------------------------------------------------------------------------
module main_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       IllegalOp
);

  state_t r_state;
  state_t w_next_state;
  logic   w_illegal;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so every flop samples the
    // pre-edge value, independent of process evaluation order.
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_FETCH;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH:  w_next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default: begin
            w_next_state = S_FETCH;
            w_illegal    = 1'b1;
          end
        endcase
      end
      // Only LW and SW reach MEMADR; anything but SW is treated as a load.
      S_MEMADR: w_next_state = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  w_next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ALUWB:  w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_ADDIWB: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  assign State     = r_state;
  assign IllegalOp = w_illegal & ~reset;

  main_control_outputs u_outputs (
    .State       (r_state),
    .MemReady    (MemReady),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .InstrDone   (InstrDone)
  );

endmodule

// File: tb/tb_main_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_control_fsm
//   Self-checking bench for main_control_fsm: a directed vector table covering
//   reset, every instruction class, memory wait states and reset abort,
//   followed by a randomized instruction stream checked against a
//   per-instruction reference model (expected state path plus counts of each
//   control pulse).
// -----------------------------------------------------------------------------
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic       InstrDone, IllegalOp;

  always #5 clk = ~clk;

  main_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .InstrDone   (InstrDone),
    .IllegalOp   (IllegalOp)
  );

  // Output bundle, MSB first:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] InstrDone IllegalOp
  logic [17:0] w_out;
  assign w_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, InstrDone, IllegalOp};

  localparam logic [17:0] PCW  = 18'h20000;
  localparam logic [17:0] PCWC = 18'h10000;
  localparam logic [17:0] IORD = 18'h08000;
  localparam logic [17:0] MRD  = 18'h04000;
  localparam logic [17:0] MWR  = 18'h02000;
  localparam logic [17:0] IRW  = 18'h01000;
  localparam logic [17:0] M2R  = 18'h00800;
  localparam logic [17:0] RDST = 18'h00400;
  localparam logic [17:0] RW   = 18'h00200;
  localparam logic [17:0] SRCA = 18'h00100;
  localparam logic [17:0] SB1  = 18'h00040;
  localparam logic [17:0] SB2  = 18'h00080;
  localparam logic [17:0] SB3  = 18'h000C0;
  localparam logic [17:0] AOP1 = 18'h00010;
  localparam logic [17:0] AOP2 = 18'h00020;
  localparam logic [17:0] PS1  = 18'h00004;
  localparam logic [17:0] PS2  = 18'h00008;
  localparam logic [17:0] DONE = 18'h00002;
  localparam logic [17:0] ILL  = 18'h00001;
  localparam logic [17:0] ALL  = 18'h3FFFF;
  localparam logic [17:0] WE   = PCW | PCWC | MRD | MWR | IRW | RW | DONE | ILL;
  localparam logic [17:0] F_RDY = PCW | MRD | IRW | SB1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JP = 6'b000010;
  localparam logic [5:0] XX = 6'b111111;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [5:0]  op;
    logic        chk_st;
    logic [3:0]  st;
    logic [17:0] mask;
    logic [17:0] out;
  } vec_t;

  localparam int NVEC = 30;
  vec_t tbl [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic mr, input logic [5:0] op,
                              input logic chk, input logic [3:0] st,
                              input logic [17:0] mask, input logic [17:0] out);
    return '{rst: rst, mr: mr, op: op, chk_st: chk, st: st, mask: mask, out: out};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BQ || op == AD || op == JP;
  endfunction

  // Reference-model stimulus for one instruction: expected state per cycle
  // and the MemReady value driven in that cycle.
  logic [3:0] st_q[$];
  logic       mr_q[$];

  task automatic push(input logic [3:0] st, input logic mr);
    st_q.push_back(st);
    mr_q.push_back(mr);
  endtask

  task automatic push_wait(input logic [3:0] st, input int waits);
    for (int w = 0; w < waits; w++) push(st, 1'b0);
    push(st, 1'b1);
  endtask

  logic [5:0] op;
  int         kind, fw, mw;
  int         c_mrd, c_mwr, c_rw, c_pcw, c_pcwc, c_irw, c_done, c_ill, c_both;
  logic       last_done, last_ill;
  logic       is_lw, is_sw, is_r, is_beq, is_addi, is_j, ok;

  initial begin
    // Directed vectors: {reset, MemReady, Opcode, check state?, state, mask, outputs}
    tbl[0]  = mk(1, 1, RT, 0, 4'd0,  WE,  18'h0);              // state unknown yet
    tbl[1]  = mk(1, 1, RT, 1, 4'd0,  ALL, SB1);                // FETCH under reset
    tbl[2]  = mk(1, 1, RT, 1, 4'd0,  ALL, SB1);
    tbl[3]  = mk(0, 1, LW, 1, 4'd0,  ALL, F_RDY);
    tbl[4]  = mk(0, 1, LW, 1, 4'd1,  ALL, SB3);
    tbl[5]  = mk(0, 1, LW, 1, 4'd2,  ALL, SRCA | SB2);
    tbl[6]  = mk(0, 1, LW, 1, 4'd3,  ALL, MRD | IORD);
    tbl[7]  = mk(0, 1, LW, 1, 4'd4,  ALL, RW | M2R | DONE);
    tbl[8]  = mk(0, 1, SW, 1, 4'd0,  ALL, F_RDY);
    tbl[9]  = mk(0, 1, SW, 1, 4'd1,  ALL, SB3);
    tbl[10] = mk(0, 1, SW, 1, 4'd2,  ALL, SRCA | SB2);
    tbl[11] = mk(0, 0, SW, 1, 4'd5,  ALL, MWR | IORD);
    tbl[12] = mk(0, 0, SW, 1, 4'd5,  ALL, MWR | IORD);
    tbl[13] = mk(0, 1, SW, 1, 4'd5,  ALL, MWR | IORD | DONE);
    tbl[14] = mk(0, 1, RT, 1, 4'd0,  ALL, F_RDY);
    tbl[15] = mk(0, 1, RT, 1, 4'd1,  ALL, SB3);
    tbl[16] = mk(0, 1, RT, 1, 4'd6,  ALL, SRCA | AOP2);
    tbl[17] = mk(0, 1, RT, 1, 4'd7,  ALL, RW | RDST | DONE);
    tbl[18] = mk(0, 1, BQ, 1, 4'd0,  ALL, F_RDY);
    tbl[19] = mk(0, 1, BQ, 1, 4'd1,  ALL, SB3);
    tbl[20] = mk(0, 1, BQ, 1, 4'd8,  ALL, SRCA | AOP1 | PCWC | PS1 | DONE);
    tbl[21] = mk(0, 1, XX, 1, 4'd0,  ALL, F_RDY);
    tbl[22] = mk(0, 1, XX, 1, 4'd1,  ALL, SB3 | ILL);
    tbl[23] = mk(0, 1, AD, 1, 4'd0,  ALL, F_RDY);
    tbl[24] = mk(0, 1, AD, 1, 4'd1,  ALL, SB3);
    tbl[25] = mk(1, 1, AD, 1, 4'd9,  ALL, SRCA | SB2);         // reset aborts ADDI
    tbl[26] = mk(0, 0, JP, 1, 4'd0,  ALL, MRD | SB1);          // FETCH, memory busy
    tbl[27] = mk(0, 1, JP, 1, 4'd0,  ALL, F_RDY);
    tbl[28] = mk(0, 1, JP, 1, 4'd1,  ALL, SB3);
    tbl[29] = mk(0, 1, JP, 1, 4'd11, ALL, PCW | PS2 | DONE);

    reset = 1'b1; MemReady = 1'b1; Opcode = RT;
    #1;
    for (int i = 0; i < NVEC; i++) begin
      reset    = tbl[i].rst;
      MemReady = tbl[i].mr;
      Opcode   = tbl[i].op;
      #3;
      if (tbl[i].chk_st)
        check($sformatf("vec%0d_state", i), {28'h0, State}, {28'h0, tbl[i].st});
      check($sformatf("vec%0d_outputs", i), {14'h0, w_out & tbl[i].mask},
            {14'h0, tbl[i].out & tbl[i].mask});
      @(posedge clk); #1;
    end

    // Randomized instruction stream; the FSM is back in FETCH here.
    reset = 1'b0;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BQ;
        4: op = AD;
        5: op = JP;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      ok      = legal(op);
      is_lw   = (op == LW);
      is_sw   = (op == SW);
      is_r    = (op == RT);
      is_beq  = (op == BQ);
      is_addi = (op == AD);
      is_j    = (op == JP);

      // Expected path through the instruction
      st_q.delete(); mr_q.delete();
      push_wait(4'd0, fw);
      push(4'd1, 1'($urandom_range(0, 1)));
      if (is_lw) begin
        push(4'd2, 1'($urandom_range(0, 1)));
        push_wait(4'd3, mw);
        push(4'd4, 1'($urandom_range(0, 1)));
      end else if (is_sw) begin
        push(4'd2, 1'($urandom_range(0, 1)));
        push_wait(4'd5, mw);
      end else if (is_r) begin
        push(4'd6, 1'($urandom_range(0, 1)));
        push(4'd7, 1'($urandom_range(0, 1)));
      end else if (is_beq) begin
        push(4'd8, 1'($urandom_range(0, 1)));
      end else if (is_addi) begin
        push(4'd9, 1'($urandom_range(0, 1)));
        push(4'd10, 1'($urandom_range(0, 1)));
      end else if (is_j) begin
        push(4'd11, 1'($urandom_range(0, 1)));
      end

      c_mrd = 0; c_mwr = 0; c_rw = 0; c_pcw = 0; c_pcwc = 0;
      c_irw = 0; c_done = 0; c_ill = 0; c_both = 0;
      last_done = 1'b0; last_ill = 1'b0;
      for (int c = 0; c < st_q.size(); c++) begin
        Opcode   = op;
        MemReady = mr_q[c];
        #3;
        check($sformatf("rnd%0d_state_c%0d", n, c), {28'h0, State}, {28'h0, st_q[c]});
        c_mrd  += int'(MemRead);
        c_mwr  += int'(MemWrite);
        c_rw   += int'(RegWrite);
        c_pcw  += int'(PCWrite);
        c_pcwc += int'(PCWriteCond);
        c_irw  += int'(IRWrite);
        c_done += int'(InstrDone);
        c_ill  += int'(IllegalOp);
        c_both += int'(InstrDone & IllegalOp);
        if (c == st_q.size() - 1) begin
          last_done = InstrDone;
          last_ill  = IllegalOp;
        end
        @(posedge clk); #1;
      end

      // Counts of each pulse over the whole instruction
      check($sformatf("rnd%0d_memread_cycles", n),  c_mrd, fw + 1 + (is_lw ? mw + 1 : 0));
      check($sformatf("rnd%0d_memwrite_cycles", n), c_mwr, is_sw ? mw + 1 : 0);
      check($sformatf("rnd%0d_regwrite_cycles", n), c_rw,  (is_lw || is_r || is_addi) ? 1 : 0);
      check($sformatf("rnd%0d_pcwrite_cycles", n),  c_pcw, 1 + (is_j ? 1 : 0));
      check($sformatf("rnd%0d_pcwritecond", n),     c_pcwc, is_beq ? 1 : 0);
      check($sformatf("rnd%0d_irwrite", n),         c_irw, 1);
      check($sformatf("rnd%0d_instrdone", n),       c_done, ok ? 1 : 0);
      check($sformatf("rnd%0d_illegalop", n),       c_ill, ok ? 0 : 1);
      check($sformatf("rnd%0d_done_last", n),       {31'h0, last_done}, {31'h0, ok});
      check($sformatf("rnd%0d_ill_last", n),        {31'h0, last_ill}, {31'h0, ~ok});
      check($sformatf("rnd%0d_done_ill_overlap", n), c_both, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
